// File: rtl/gs_row_sequencer_pkg.sv
// Shared sizing, fixed-point format constants and FSM encoding for the
// Gauss-Seidel row sequencer.
package gs_pkg;
    localparam int N        = 8;
    localparam int ITER     = 16;
    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam int SWEEP_W  = (ITER > 1) ? $clog2(ITER) : 1;

    localparam int X_W      = 32;
    localparam int X_FRAC   = 24;
    localparam int COEF_W   = 8;
    localparam int INV_W    = 32;
    localparam int INV_FRAC = 30;

    typedef enum logic [2:0] {LOAD, CLR, START, WAIT, OUT} state_e;
endpackage

// File: rtl/gs_row_sequencer_if.sv
// Row load, core operand/result and solution stream bundle of the sequencer.
interface gs_row_sequencer_if;
    import gs_pkg::*;

    logic [N*COEF_W-1:0]     i_a;
    logic [COEF_W-1:0]       i_b;
    logic [INV_W-1:0]        i_inv;
    logic                    i_valid;
    logic                    o_ready;

    logic                    o_core_clr;
    logic                    o_core_start;
    logic [(N-1)*COEF_W-1:0] o_core_a;
    logic [(N-1)*X_W-1:0]    o_core_x;
    logic [COEF_W-1:0]       o_core_b;
    logic [INV_W-1:0]        o_core_inv;
    logic                    i_core_done;
    logic [X_W-1:0]          i_core_x;

    logic [X_W-1:0]          o_x;
    logic [IDX_W-1:0]        o_x_idx;
    logic                    o_x_valid;
    logic                    i_x_ready;

    modport master (
        output i_a, i_b, i_inv, i_valid, i_core_done, i_core_x, i_x_ready,
        input  o_ready, o_core_clr, o_core_start, o_core_a, o_core_x,
               o_core_b, o_core_inv, o_x, o_x_idx, o_x_valid
    );

    modport slave (
        input  i_a, i_b, i_inv, i_valid, i_core_done, i_core_x, i_x_ready,
        output o_ready, o_core_clr, o_core_start, o_core_a, o_core_x,
               o_core_b, o_core_inv, o_x, o_x_idx, o_x_valid
    );
endinterface

// File: rtl/gs_row_sequencer_offdiag_mux.sv
// Drops column `row` from a coefficient row and the x vector, packing the
// remaining N-1 terms in ascending column order with slot 0 in the MSBs.
module gs_offdiag_mux
    import gs_pkg::*;
(
    input  logic [IDX_W-1:0]             row_i,
    input  logic [N-1:0][COEF_W-1:0]     coef_i,   // element N-1 holds column 0
    input  logic [N-1:0][X_W-1:0]        x_i,      // element j holds x_j
    output logic [N-2:0][COEF_W-1:0]     a_o,      // element N-2 holds slot 0
    output logic [N-2:0][X_W-1:0]        x_o
);
    for (genvar k = 0; k < N-1; k++) begin : g_slot
        logic [IDX_W-1:0] col;

        assign col          = (IDX_W'(k) < row_i) ? IDX_W'(k) : IDX_W'(k+1);
        assign a_o[N-2-k]   = coef_i[IDX_W'(N-1) - col];
        assign x_o[N-2-k]   = x_i[col];
    end
endmodule

// File: rtl/gs_row_sequencer.sv
// Loads an N-row system, drives the per-row core for ITER Gauss-Seidel sweeps
// with in-place write-back, then streams the solution vector out.
module gs_row_sequencer
    import gs_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    gs_row_sequencer_if.slave bus
);
    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic [SWEEP_W-1:0]        sweep_q, sweep_d;
    logic [N-1:0][N*COEF_W-1:0] a_q;
    logic [N-1:0][COEF_W-1:0]  b_q;
    logic [N-1:0][INV_W-1:0]   inv_q;
    logic [N-1:0][X_W-1:0]     x_q;

    logic                      load_acc, last_row, last_sweep, wb;
    logic [N-2:0][COEF_W-1:0]  mux_a;
    logic [N-2:0][X_W-1:0]     mux_x;

    // One counter serves as load index, row index and output index.
    assign last_row   = (cnt_q == IDX_W'(N-1));
    assign last_sweep = (sweep_q == SWEEP_W'(ITER-1));
    assign load_acc   = (state_q == LOAD) && bus.i_valid;
    assign wb         = (state_q == WAIT) && bus.i_core_done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sweep_d = sweep_q;
        case (state_q)
            LOAD: if (load_acc) begin
                if (last_row) begin
                    cnt_d   = '0;
                    sweep_d = '0;
                    state_d = CLR;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            CLR:   state_d = START;
            START: state_d = WAIT;
            WAIT: if (wb) begin
                if (!last_row) begin
                    cnt_d   = cnt_q + IDX_W'(1);
                    state_d = CLR;
                end else if (!last_sweep) begin
                    cnt_d   = '0;
                    sweep_d = sweep_q + SWEEP_W'(1);
                    state_d = CLR;
                end else begin
                    cnt_d   = '0;
                    state_d = OUT;
                end
            end
            OUT: if (bus.i_x_ready) begin
                if (last_row) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            sweep_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            inv_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sweep_q <= sweep_d;
            if (load_acc) begin
                a_q[cnt_q]   <= bus.i_a;
                b_q[cnt_q]   <= bus.i_b;
                inv_q[cnt_q] <= bus.i_inv;
            end
            // Write-back lands before the next CLR, so the next row sees it.
            if (load_acc && last_row)
                x_q <= '0;
            else if (wb)
                x_q[cnt_q] <= bus.i_core_x;
        end
    end

    gs_offdiag_mux u_mux (
        .row_i  (cnt_q),
        .coef_i (a_q[cnt_q]),
        .x_i    (x_q),
        .a_o    (mux_a),
        .x_o    (mux_x)
    );

    assign bus.o_ready      = (state_q == LOAD);
    assign bus.o_core_clr   = (state_q == CLR);
    assign bus.o_core_start = (state_q == START);
    assign bus.o_core_a     = mux_a;
    assign bus.o_core_x     = mux_x;
    assign bus.o_core_b     = b_q[cnt_q];
    assign bus.o_core_inv   = inv_q[cnt_q];
    assign bus.o_x_valid    = (state_q == OUT);
    assign bus.o_x          = (state_q == OUT) ? x_q[cnt_q] : '0;
    assign bus.o_x_idx      = (state_q == OUT) ? cnt_q : '0;
endmodule

// File: tb/tb_gs_row_sequencer.sv
// Directed bench for gs_row_sequencer with a fixed-latency behavioural core stub.
module tb_gs_row_sequencer;
    import gs_pkg::*;

    localparam int LAT       = 8;
    localparam int SOLVE_CYC = N * ITER * (LAT + 3) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gs_row_sequencer_if bus();
    gs_row_sequencer dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    int   starts = 0;
    int   base   = 0;
    bit   stub_mode = 1'b0;   // 0: x = b*inv (diagonal systems), 1: x = row index
    logic man_done  = 1'b0;

    // Core stub: done arrives LAT+1 cycles after the start cycle.
    logic        stub_busy;
    logic [3:0]  stub_cnt;
    logic [31:0] stub_res;
    logic signed [39:0] prod;
    assign prod = $signed({{32{bus.o_core_b[7]}}, bus.o_core_b}) *
                  $signed({{8{bus.o_core_inv[31]}}, bus.o_core_inv});

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy <= 1'b0;
            stub_cnt  <= '0;
            stub_res  <= '0;
        end else if (bus.o_core_start) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 4'(LAT);
            stub_res  <= stub_mode ? 32'((starts - base) % N) : prod[37:6];
        end else if (stub_busy) begin
            if (stub_cnt == 0) stub_busy <= 1'b0;
            else               stub_cnt  <= stub_cnt - 4'd1;
        end
    end

    assign bus.i_core_done = (stub_busy && stub_cnt == 0) || man_done;
    assign bus.i_core_x    = man_done ? 32'hDEAD_BEEF : stub_res;

    always @(posedge clk) if (bus.o_core_start) starts <= starts + 1;

    logic [(N-1)*X_W-1:0]    snap1_x = '0;
    logic [(N-1)*X_W-1:0]    snap3_x = '0;
    logic [(N-1)*COEF_W-1:0] snap3_a = '0;
    always @(negedge clk) begin
        if (bus.o_core_start) begin
            if (starts - base == 1)  snap1_x <= bus.o_core_x;
            if (starts - base == 11) begin
                snap3_a <= bus.o_core_a;
                snap3_x <= bus.o_core_x;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind 0: 4*I, b=i, inv=0.25; kind 1: as 0 but row 0 has b=1, inv=1.0;
    // kind 2: every row 01..08, stub returns the row index.
    function automatic logic [31:0] expv(input int kind, input int i);
        if (kind == 2)               return 32'(i);
        if (kind == 1 && i == 0)     return 32'h0100_0000;
        return 32'(i) << 22;
    endfunction

    task automatic load_sys(input int kind, input bit gaps);
        logic [63:0] a;
        for (int r = 0; r < N; r++) begin
            bus.i_valid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            a = 64'h04;
            a = a << ((N - 1 - r) * 8);
            bus.i_a   = (kind == 2) ? 64'h0102_0304_0506_0708 : a;
            bus.i_b   = (kind == 2) ? 8'd0 : (kind == 1 && r == 0) ? 8'd1 : 8'(r);
            bus.i_inv = (kind == 2) ? 32'd0 : (kind == 1 && r == 0) ? 32'h4000_0000 : 32'h1000_0000;
            bus.i_valid = 1'b1;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
    endtask

    // Called at the negedge of the first cycle after the last accept.
    task automatic wait_out(input string tag, input bit spur);
        int n = 1;
        if (spur) begin
            man_done = 1'b1;  @(negedge clk);   // CLR
            chk("spur_start_state", bus.o_core_start, 1'b1);
            @(negedge clk);                      // WAIT
            man_done = 1'b0;
            n = 3;
        end
        while (!bus.o_x_valid && n < SOLVE_CYC + 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, SOLVE_CYC);
    endtask

    task automatic read_out(input int kind, input bit stall);
        for (int i = 0; i < N; i++) begin
            chk("out_valid", bus.o_x_valid, 1'b1);
            chk("out_idx",   bus.o_x_idx, i);
            chk("out_x",     bus.o_x, expv(kind, i));
            if (stall && $urandom_range(0, 1) == 1) begin
                bus.i_x_ready = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk("hold_idx", bus.o_x_idx, i);
                    chk("hold_x",   bus.o_x, expv(kind, i));
                end
            end
            bus.i_x_ready = 1'b1;
            @(negedge clk);
        end
        bus.i_x_ready = 1'b0;
        chk("back_to_load", bus.o_ready, 1'b1);
        chk("out_done",     bus.o_x_valid, 1'b0);
    endtask

    initial begin
        int t;
        bus.i_a = '0; bus.i_b = '0; bus.i_inv = '0;
        bus.i_valid = 1'b0; bus.i_x_ready = 1'b0;

        #12;
        chk("rst_ready", bus.o_ready, 1'b1);
        chk("rst_clr",   bus.o_core_clr, 1'b0);
        chk("rst_start", bus.o_core_start, 1'b0);
        chk("rst_a",     bus.o_core_a, '0);
        chk("rst_x",     bus.o_core_x, '0);
        chk("rst_b",     bus.o_core_b, '0);
        chk("rst_inv",   bus.o_core_inv, '0);
        chk("rst_ox",    bus.o_x, '0);
        chk("rst_oidx",  bus.o_x_idx, '0);
        chk("rst_ovld",  bus.o_x_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Done pulse while loading is ignored.
        man_done = 1'b1; @(negedge clk); man_done = 1'b0;
        chk("spur_load_ready", bus.o_ready, 1'b1);
        chk("spur_load_x",     bus.o_core_x, '0);

        // Solve A: freshness system, spurious done in CLR/START.
        base = starts; stub_mode = 1'b0;
        load_sys(1, 1'b0);
        chk("clr_after_load", bus.o_core_clr, 1'b1);
        wait_out("latency_a", 1'b1);
        chk("starts_a", starts - base, N * ITER);
        chk("fresh_slot0", snap1_x[(N-1)*X_W-1 -: X_W], 32'h0100_0000);
        read_out(1, 1'b0);

        // Solve B: operand ordering, load gaps and output stalls.
        base = starts; stub_mode = 1'b1;
        load_sys(2, 1'b1);
        wait_out("latency_b", 1'b0);
        chk("order_a", snap3_a, 56'h01_0203_0506_0708);
        chk("order_x", snap3_x, {32'd0, 32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd7});
        read_out(2, 1'b1);

        // Solve C: reset in the middle of sweep 5.
        base = starts; stub_mode = 1'b0;
        load_sys(0, 1'b0);
        t = 0;
        while (starts - base < 5 * N + 3 && t < SOLVE_CYC) begin
            @(negedge clk);
            t++;
        end
        chk("reached_sweep5", starts - base, 5 * N + 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.o_ready, 1'b1);
        chk("mid_rst_start", bus.o_core_start, 1'b0);
        chk("mid_rst_x",     bus.o_core_x, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        man_done = 1'b1; @(negedge clk); man_done = 1'b0;
        chk("post_rst_ready", bus.o_ready, 1'b1);
        chk("post_rst_clr",   bus.o_core_clr, 1'b0);
        chk("post_rst_x",     bus.o_core_x, '0);
        chk("post_rst_ovld",  bus.o_x_valid, 1'b0);

        // Solve D: fresh diagonal solve after the reset.
        base = starts;
        load_sys(0, 1'b1);
        wait_out("latency_d", 1'b0);
        chk("starts_d", starts - base, N * ITER);
        read_out(0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
